// File: rtl/cache_event_monitor.sv
// -----------------------------------------------------------------------------
// cache_event_monitor
//   On-chip observation of cache lookup events. Each cycle one lookup event may
//   be sampled. The block keeps saturating event counters (per-way hit, miss,
//   dirty-evict, multi-hit, total) and captures events into a trace FIFO. The
//   FIFO fills either continuously or after a set-index trigger, and it is
//   drained through a valid/ready port.
//
//   Optional feature macro: CACHE_MON_TSTAMP_EN
//     defined   -> a TS_W free-running timestamp is prepended to each entry
//     undefined -> no timestamp register; entries are IDX_W+CMD_W+ENC_W+2 bits
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mon_en               monitor enable (freezes FSM/counters/pushes when low)
//   clr                  synchronous clear of counters, FIFO, overflow and FSM
//   trig_mode            0 = capture every event, 1 = capture from index match
//   trig_index           trigger set index
//   ev_valid             event strobe
//   ev_hit_way           hit vector (all-zero = miss)
//   ev_index             set index of the event
//   ev_bit_cmd           bit command issued for the event
//   ev_dirty_evict       event caused a dirty victim writeback
//   cnt_sel / cnt_rdata  counter select / registered counter value
//   trc_valid/ready/data trace FIFO head and pop handshake
//   trc_ovf              sticky: an entry was dropped because the FIFO was full
//   trc_done             trigger capture window complete
// -----------------------------------------------------------------------------
module cache_event_monitor #(
  parameter int WAYS        = 4,
  parameter int IDX_W       = 10,
  parameter int CMD_W       = 4,
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int TS_W        = 16,
  localparam int ENC_W      = $clog2(WAYS),
`ifdef CACHE_MON_TSTAMP_EN
  localparam int ENT_W      = TS_W + IDX_W + CMD_W + ENC_W + 2
`else
  // TS_W has no effect on the entry width without timestamps
  localparam int ENT_W      = IDX_W + CMD_W + ENC_W + 2 + (0 * TS_W)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic             clr,
  input  logic             trig_mode,
  input  logic [IDX_W-1:0] trig_index,
  input  logic             ev_valid,
  input  logic [WAYS-1:0]  ev_hit_way,
  input  logic [IDX_W-1:0] ev_index,
  input  logic [CMD_W-1:0] ev_bit_cmd,
  input  logic             ev_dirty_evict,
  input  logic [7:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_rdata,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [ENT_W-1:0] trc_data,
  output logic             trc_ovf,
  output logic             trc_done
);

  localparam int AW   = $clog2(TRACE_DEPTH);
  localparam int PC_W = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Index of the lowest set bit; zero when no bit is set
  function automatic logic [ENC_W-1:0] lowest_way(input logic [WAYS-1:0] v);
    logic [ENC_W-1:0] enc;
    enc = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) enc = ENC_W'(i);
    end
    return enc;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t            state_r, state_s;
  logic [PC_W-1:0]   push_cnt_r, push_cnt_s;
  logic [CNT_W-1:0]  hit_cnt_r [WAYS];
  logic [CNT_W-1:0]  miss_cnt_r, dirty_cnt_r, multi_cnt_r, total_cnt_r;
  logic [CNT_W-1:0]  cnt_rdata_r, rd_mux_s;
  logic [ENT_W-1:0]  mem_r [TRACE_DEPTH];
  logic [AW:0]       wptr_r, rptr_r;
  logic              ovf_r;
  logic              accept_s, push_s, pop_s, wr_s, drop_s, full_s, empty_s;
  logic              is_hit_s, is_miss_s, is_multi_s;
  logic [ENC_W-1:0]  way_enc_s;
  logic [ENT_W-1:0]  entry_s;

  // Event acceptance and hit classification
  always_comb begin
    accept_s   = ev_valid & mon_en & ~clr;
    way_enc_s  = lowest_way(ev_hit_way);
    is_miss_s  = (ev_hit_way == '0);
    is_hit_s   = ($countones(ev_hit_way) == 1);
    is_multi_s = ~is_miss_s & ~is_hit_s;
  end

`ifdef CACHE_MON_TSTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running timestamp, advancing only while the monitor is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_r <= '0;
    else if (clr)    ts_r <= '0;
    else if (mon_en) ts_r <= ts_r + TS_W'(1);
    else             ts_r <= ts_r;
  end

  // Trace entry assembly with timestamp prefix
  always_comb begin
    entry_s = {ts_r, ev_index, ev_bit_cmd, way_enc_s, ~is_miss_s, ev_dirty_evict};
  end
`else
  // Trace entry assembly
  always_comb begin
    entry_s = {ev_index, ev_bit_cmd, way_enc_s, ~is_miss_s, ev_dirty_evict};
  end
`endif

  // Capture FSM next state; push_cnt counts pushes since the trigger
  always_comb begin
    state_s    = state_r;
    push_s     = 1'b0;
    push_cnt_s = push_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (mon_en) state_s = trig_mode ? ST_ARMED : ST_CAPTURE;
        else        state_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (accept_s && (ev_index == trig_index)) begin
          push_s     = 1'b1;
          push_cnt_s = PC_W'(1);
          state_s    = ST_CAPTURE;
        end else begin
          state_s    = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (accept_s) begin
          push_s = 1'b1;
          if (trig_mode) begin
            // This push completes the window when it is the DEPTH-th one
            if (push_cnt_r == PC_W'(TRACE_DEPTH - 1)) state_s = ST_DONE;
            else                                      state_s = ST_CAPTURE;
            if (push_cnt_r != PC_W'(TRACE_DEPTH)) push_cnt_s = push_cnt_r + PC_W'(1);
            else                                  push_cnt_s = push_cnt_r;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state and push counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      push_cnt_r <= '0;
    end else if (clr) begin
      state_r    <= ST_IDLE;
      push_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      push_cnt_r <= push_cnt_s;
    end
  end

  // FIFO status; a full push still lands when a pop frees the slot this cycle
  always_comb begin
    empty_s = (wptr_r == rptr_r);
    full_s  = ((wptr_r - rptr_r) == PC_W'(TRACE_DEPTH));
    pop_s   = ~empty_s & trc_ready;
    wr_s    = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
      ovf_r  <= 1'b0;
    end else if (clr) begin
      wptr_r <= '0;
      rptr_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_s)   wptr_r <= wptr_r + PC_W'(1);
      if (pop_s)  rptr_r <= rptr_r + PC_W'(1);
      if (drop_s) ovf_r  <= 1'b1;
    end
  end

  // FIFO storage; stale contents are never visible because the head is masked
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wptr_r[AW-1:0]] <= entry_s;
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) hit_cnt_r[w] <= '0;
      miss_cnt_r  <= '0;
      dirty_cnt_r <= '0;
      multi_cnt_r <= '0;
      total_cnt_r <= '0;
    end else if (clr) begin
      for (int w = 0; w < WAYS; w++) hit_cnt_r[w] <= '0;
      miss_cnt_r  <= '0;
      dirty_cnt_r <= '0;
      multi_cnt_r <= '0;
      total_cnt_r <= '0;
    end else if (accept_s) begin
      total_cnt_r <= sat_inc(total_cnt_r);
      if (is_hit_s)   hit_cnt_r[way_enc_s] <= sat_inc(hit_cnt_r[way_enc_s]);
      if (is_miss_s)  miss_cnt_r  <= sat_inc(miss_cnt_r);
      if (is_multi_s) multi_cnt_r <= sat_inc(multi_cnt_r);
      if (ev_dirty_evict) dirty_cnt_r <= sat_inc(dirty_cnt_r);
    end
  end

  // Counter read mux over the current (pre-update) counter values
  always_comb begin
    rd_mux_s = '0;
    if (cnt_sel < 8'(WAYS))          rd_mux_s = hit_cnt_r[cnt_sel[ENC_W-1:0]];
    else if (cnt_sel == 8'(WAYS))     rd_mux_s = miss_cnt_r;
    else if (cnt_sel == 8'(WAYS + 1)) rd_mux_s = dirty_cnt_r;
    else if (cnt_sel == 8'(WAYS + 2)) rd_mux_s = multi_cnt_r;
    else if (cnt_sel == 8'(WAYS + 3)) rd_mux_s = total_cnt_r;
    else                              rd_mux_s = '0;
  end

  // Registered counter read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_rdata_r <= '0;
    else        cnt_rdata_r <= rd_mux_s;
  end

  assign cnt_rdata = cnt_rdata_r;
  assign trc_valid = ~empty_s;
  assign trc_data  = empty_s ? '0 : mem_r[rptr_r[AW-1:0]];
  assign trc_ovf   = ovf_r;
  assign trc_done  = (state_r == ST_DONE);

endmodule

// File: doc/cache_event_monitor.md
Name: cache_event_monitor

Overview:
- Synthesizable, parametrised cache observation block that replaces simulation-only probe wires with on-chip visibility.
- Samples one cache lookup event per cycle from the cache controller: hit-way vector, set index, bit command and dirty-evict flag.
- Keeps saturating per-way hit, miss, dirty-evict, multi-hit and total counters.
- Captures events into a trace FIFO, either continuously or after a set-index trigger, and drains it over a valid/ready port.

Parameters:
- WAYS, 4, associativity (power of 2, ≥2); ENC_W = $clog2(WAYS).
- IDX_W, 10, set-index width.
- CMD_W, 4, bit-command width (matches fsm_bit_cmd encoding).
- CNT_W, 32, event-counter width.
- TRACE_DEPTH, 16, trace FIFO entries (power of 2, ≥2).
- TS_W, 16, timestamp width (used only with CACHE_MON_TSTAMP_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mon_en  in  1  monitor enable; events are ignored while low.
- clr  in  1  synchronous clear of counters, FIFO, overflow flag and FSM (FSM returns to IDLE).
- trig_mode  in  1  0 = capture every event; 1 = capture starts on index match.
- trig_index  in  IDX_W  trigger set index.
- ev_valid  in  1  event strobe.
- ev_hit_way  in  WAYS  hit vector; all-zero = miss.
- ev_index  in  IDX_W  set index of the event.
- ev_bit_cmd  in  CMD_W  bit command issued for the event.
- ev_dirty_evict  in  1  event caused a dirty victim writeback.
- cnt_sel  in  8  counter select.
- cnt_rdata  out  CNT_W  selected counter, registered.
- trc_valid  out  1  FIFO non-empty.
- trc_ready  in  1  consumer pop.
- trc_data  out  ENT_W  head entry.
- trc_ovf  out  1  sticky: an entry was dropped because the FIFO was full.
- trc_done  out  1  FSM is in DONE.

Behaviour:
- Reset (rst_n low, asynchronous): all counters, FIFO pointers, timestamp, cnt_rdata and trc_ovf = 0; FSM = IDLE; trc_valid = 0; trc_done = 0; trc_data = 0.
- Accepted event: ev_valid & mon_en & ~clr. If clr and ev_valid are high in the same cycle, clr wins and the event is neither counted nor traced.
- Counter update on each accepted event, 1 cycle after ev_valid:
  - total += 1.
  - Exactly one bit set in ev_hit_way: hit[way] += 1.
  - All bits zero: miss += 1.
  - More than one bit set: multihit += 1 and no per-way counter changes.
  - ev_dirty_evict: dirty += 1, independent of the hit or miss classification.
  - All counters saturate at all-ones; they never wrap.
- Counter read (cnt_sel map):
  - 0..WAYS-1 = hit[way]; WAYS = miss; WAYS+1 = dirty; WAYS+2 = multihit; WAYS+3 = total; any other value reads 0.
  - cnt_rdata is registered, 1-cycle latency.
  - When cnt_sel selects a counter updating in the same cycle, the pre-update value is returned.
- Entry format, MSB→LSB: [ts] , index , cmd , way_enc , hit , dirty.
  - ENT_W = [TS_W+] IDX_W + CMD_W + ENC_W + 2.
  - way_enc is the lowest set bit of ev_hit_way; it is 0 on a miss.
  - hit = |ev_hit_way.
- FSM:
  - IDLE: entered from reset or clr. mon_en=1 moves to ARMED if trig_mode=1, or to CAPTURE if trig_mode=0.
  - ARMED: no FIFO writes. An accepted event with ev_index==trig_index is written (the trigger event is itself entry 0) and the FSM moves to CAPTURE.
  - CAPTURE: every accepted event is pushed.
    - trig_mode=1: after TRACE_DEPTH total pushes since the trigger, the FSM moves to DONE.
    - trig_mode=0: the FSM never leaves CAPTURE.
  - DONE: no pushes; trc_done=1; pops are still allowed; exit only via clr or reset.
  - mon_en low in any state freezes the state, counters and pushes. Pops remain allowed.
- FIFO:
  - trc_data is the head entry, valid when trc_valid=1. A pop happens when trc_valid & trc_ready.
  - Push and pop in the same cycle while full: both take effect, occupancy is unchanged, no overflow.
  - Push while full with no pop: the entry is dropped and trc_ovf is set until clr.
  - Pop while empty: ignored.
  - Pointers wrap modulo TRACE_DEPTH; an extra pointer bit distinguishes full from empty.

Optional Feature:
- Macro: CACHE_MON_TSTAMP_EN.
- Defined:
  - A TS_W free-running timestamp increments every cycle while mon_en=1 and wraps modulo 2^TS_W.
  - clr and reset zero the timestamp.
  - Each entry's ts field holds the timestamp value in the cycle of the event.
- Not defined: no timestamp register, ts field is absent, and ENT_W = IDX_W+CMD_W+ENC_W+2.

Test Plan:
- Reset then mon_en=1, trig_mode=0; 3 events hit_way=4'b0100 and 2 events hit_way=0, one of them with dirty=1 → cnt_sel=2 reads 3, sel=4 reads 2, sel=5 reads 1, sel=7 reads 5, sel=6 reads 0.
- Event with hit_way=4'b0110 → multihit=1, hit[1]=hit[2]=0; the traced entry has way_enc=1, hit=1.
- trig_mode=1, trig_index=0x2A; events on indexes 0x01, 0x02, 0x2A, 0x03… with trc_ready=0 → FIFO first entry index=0x2A; trc_done=1 after 16 pushes; trc_ovf=0; further events are not pushed.
- trig_mode=0, trc_ready=0, 17 events → 16 entries held, trc_ovf=1. Then trc_ready=1 with one event per cycle → no further ovf; entries drain in order.
- ev_valid and clr in the same cycle after 5 counted events → all counters 0, the event is not counted, FSM=IDLE. Also assert rst_n low mid-CAPTURE → trc_valid=0 immediately, asynchronously.
- Saturation with CNT_W=4 override: 20 misses → miss reads 15.
- With CACHE_MON_TSTAMP_EN: events at cycles 3 and 7 after mon_en → ts delta = 4.
